// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM generator: decoder states and command byte layout.
package pwm_gen_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_HI_BIT = 6;

  typedef enum logic {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } dcd_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a selectable reset value.
module sync_2ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/instr_dcd.sv
// Two-byte SPI frame decoder: command byte then data byte, producing one-cycle
// register read/write strobes. Optional address range check: DCD_ADDR_CHECK_EN.
module instr_dcd
  import pwm_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n_i,
  input  logic              byte_sync_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              hi_sel_o,
  output logic [DATA_W-1:0] data_write_o,
  input  logic [DATA_W-1:0] data_read_i,
  output logic              err_o
);

  dcd_state_e        state_q, state_d;
  logic              rw_q, rw_d;
  logic              hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] dw_q, dw_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              cs_sync;
  logic              cmd_take;
  logic              cmd_bad;
  logic              bad_q;

  sync_2ff #(
    .RstVal (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs_n_i),
    .q_o   (cs_sync)
  );

  // A command byte is accepted only while the frame is live.
  assign cmd_take = !cs_sync && byte_sync_i && (state_q == S_CMD);

`ifdef DCD_ADDR_CHECK_EN
  logic err_q;

  assign cmd_bad = (data_in_i[ADDR_W-1:0] > MAX_ADDR);

  // Remember whether the current frame's address is out of range; err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (cmd_take) begin
      bad_q <= cmd_bad;
      if (cmd_bad) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign cmd_bad = 1'b0;
  assign bad_q   = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state: frame sequencing, strobe generation and read-data capture.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    dw_d    = dw_q;
    dout_d  = dout_q;

    // Register file answers combinationally in the strobe cycle.
    if (read_q) dout_d = data_read_i;

    if (cs_sync) begin
      // Deselect aborts the frame and wins over a coincident byte.
      state_d = S_CMD;
      dout_d  = '0;
    end else if (byte_sync_i) begin
      unique case (state_q)
        S_CMD: begin
          rw_d    = data_in_i[CMD_RW_BIT];
          hi_d    = data_in_i[CMD_HI_BIT];
          addr_d  = data_in_i[ADDR_W-1:0];
          read_d  = !data_in_i[CMD_RW_BIT] && !cmd_bad;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (rw_q && !bad_q) begin
            write_d = 1'b1;
            dw_d    = data_in_i;
          end
          dout_d  = '0;
          state_d = S_CMD;
        end
        default: state_d = S_CMD;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CMD;
      rw_q    <= 1'b0;
      hi_q    <= 1'b0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      dw_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      dw_q    <= dw_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out_o   = dout_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign addr_o       = addr_q;
  assign hi_sel_o     = hi_q;
  assign data_write_o = dw_q;

endmodule

// File: doc/instr_dcd.md
Name: instr_dcd

Overview:
Byte-level instruction decoder sitting directly downstream of the SPI bridge in the PWM generator.
- Consumes the bridge's received bytes (data_in, qualified by byte_sync) and turns two-byte SPI frames into single-cycle register read/write strobes toward the PWM register file.
- Supplies the bridge's data_out with read data for the second byte of a read frame.
- Frame format: byte 0 = command, byte 1 = data (write payload, or dummy byte while read data shifts out on MISO).

Parameters:
ADDR_W, 6, register address width; the command byte carries the address in bits [ADDR_W-1:0].
MAX_ADDR, 6'h13, highest implemented register address; used only when DCD_ADDR_CHECK_EN is defined.

Ports:
clk  input  1  system clock; same domain as the SPI bridge's byte_sync and data_in
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  SPI chip select, asynchronous to clk; synchronised internally
byte_sync  input  1  one-clk pulse from bridge; data_in valid in that cycle
data_in  input  8  byte received from master
data_out  output  8  byte for the bridge to shift out on MISO
read  output  1  one-clk register read strobe
write  output  1  one-clk register write strobe
addr  output  ADDR_W  register address, valid while read or write is high
hi_sel  output  1  byte-lane select (1 = upper byte of 16-bit register)
data_write  output  8  write data, valid while write is high
data_read  input  8  register file read data; combinational, valid in the same cycle as read
err  output  1  sticky address error flag (DCD_ADDR_CHECK_EN only, else tied 0)

Behaviour:
Reset: clk and rst_n are the single clock and the asynchronous active-low reset.
- During reset: state=S_CMD; data_out, addr, data_write = 0; read, write, hi_sel, err = 0.

Command byte: bit7 = R/W (1 = write, 0 = read), bit6 = hi_sel, bits[ADDR_W-1:0] = address. Any unused bits are ignored.

FSM, two states:
- S_CMD, on byte_sync:
  - latch rw, hi_sel and addr from data_in; go to S_DATA.
  - If read: read=1 in cycle T+1 (T = byte_sync cycle); data_read is captured into data_out at the end of T+1.
  - data_out is therefore stable before the first SCLK edge of byte 1.
- S_DATA, on byte_sync:
  - If write: write=1 in cycle T+1 with data_write=data_in(T) and the latched addr/hi_sel.
  - If read: data_in is ignored, no strobe.
  - Either way go to S_CMD; data_out clears to 0x00 at T+1.
- Strobes are exactly one clk wide. read and write are never high simultaneously.
- addr/hi_sel hold their latched values until the next command byte.

cs_n handling:
- cs_n passes through a 2-FF synchroniser.
- Synchronised cs_n high forces state=S_CMD and clears data_out. Any pending write is dropped (no strobe).
- If byte_sync and synchronised cs_n high coincide, the cs_n abort wins.

Boundary conditions:
- Frame of one byte only (cs_n rises in S_DATA): no write occurs. A read strobe already issued is not retracted.
- Back-to-back frames with no idle byte_sync gap are supported; byte_sync arrives at most once per 8 SCLK periods.
- rst_n asserted mid-frame: immediate return to reset values.

Optional Feature:
DCD_ADDR_CHECK_EN
- Defined: a command with addr > MAX_ADDR suppresses the read/write strobe. Read data_out is forced to 0x00, and err is set one cycle after the offending command byte. err stays sticky until reset.
- Not defined: all addresses pass through, err is constant 0, and no comparator is synthesised.

Decomposition:
- Shared package pwm_gen_pkg: state encoding (S_CMD, S_DATA), command-bit positions (CMD_RW_BIT=7, CMD_HI_BIT=6), DATA_W=8.
- One sub-module: sync_2ff (generic 2-flop synchroniser, async active-low reset to 1 for cs_n), reusable elsewhere in the design.

Test Plan:
1. Write: cs_n low; byte_sync with 0x85, then byte_sync with 0x3C -> one write pulse at T+1 of byte 1; addr=0x05, hi_sel=0, data_write=0x3C; read never high.
2. Read: data_read=0xA5 at addr 0x02; bytes 0x42 then 0xFF -> read pulse at T+1 with addr=0x02, hi_sel=1; data_out=0xA5 from T+2 until byte-1 byte_sync+1, then 0x00.
3. Abort: byte_sync 0x81, then cs_n high for 4 clk, then new frame 0x03/0x00 -> no write from the first frame; second frame decodes as a read of addr 0x03.
4. Back-to-back: four frames (W 0x01=0x11, R 0x01, W 0x02=0x22, R 0x02) with minimum byte_sync spacing -> exactly two write and two read pulses, correct addr/data in each.
5. Reset mid-frame: rst_n low between byte 0 and byte 1 -> all outputs 0 immediately; the next byte_sync is treated as a command.
6. (DCD_ADDR_CHECK_EN, MAX_ADDR=0x13) write cmd 0x94 -> no write, err=1 and stays high; read cmd 0x14 -> no read, data_out=0x00.
